red_pitaya_iq_phase_stepper: RTL and testbench

- Upstream stage of the IQ block; drives its 14-bit shift_input, which sets the demodulation phase offset.
- Sweeps the phase offset between programmable start/stop limits, with a programmable step and dwell time per point.
- Supports sawtooth or triangle sweeps, either single-shot or continuous.
- Configured over the same PS register bus as the IQ block.

---
 rtl/red_pitaya_iq_phase_stepper.sv | 185 ++++++++++++++++++
 tb/tb_red_pitaya_iq_phase_stepper.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/red_pitaya_iq_phase_stepper.sv
// rtl/red_pitaya_iq_phase_stepper.sv - programmable phase-offset sweeper feeding the IQ block shift_input
module red_pitaya_iq_phase_stepper #(
  parameter int PHASEBITS = 14,
  parameter int DWELLBITS = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 sync_i,
  input  logic [15:0]          addr,
  input  logic                 wen,
  input  logic                 ren,
  input  logic [31:0]          wdata,
  output logic                 ack,
  output logic [31:0]          rdata,
  output logic [PHASEBITS-1:0] shift_o,
  output logic                 step_o,
  output logic                 done_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_UP   = 2'd1,
    ST_DOWN = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t               state, state_d;
  logic                 ctrl_en, ctrl_mode, ctrl_single;
  logic [PHASEBITS-1:0] start_r, stop_r, step_r;
  logic [PHASEBITS-1:0] shift_r, shift_d;
  logic [DWELLBITS-1:0] dwell_r, dwell_cnt, dwell_cnt_d;
  logic [31:0]          sweep_count, sweep_count_d;

  logic                 ctrl_wr, restart_wr, disable_wr, restart;
  logic                 expire, degenerate;
  logic [PHASEBITS-1:0] step_eff;
  logic [PHASEBITS:0]   up_sum, dn_diff, turn_diff, rise_sum;
  logic [PHASEBITS-1:0] up_next, dn_next, turn_next, rise_next;

  // A disable write must beat a coincident sync pulse, so sync only restarts when no disable is pending.
  assign ctrl_wr    = wen && (addr == 16'h0100);
  assign restart_wr = ctrl_wr && wdata[0];
  assign disable_wr = ctrl_wr && !wdata[0];
  assign restart    = restart_wr || (sync_i && ctrl_en && !disable_wr);

  assign expire     = (dwell_cnt == '0);
  assign degenerate = (start_r >= stop_r);
  assign step_eff   = (step_r == '0) ? PHASEBITS'(1) : step_r;

  // All arithmetic is one bit wider so clamping happens before any modular wrap.
  assign up_sum    = {1'b0, shift_r} + {1'b0, step_eff};
  assign up_next   = (up_sum > {1'b0, stop_r}) ? stop_r : up_sum[PHASEBITS-1:0];
  assign dn_diff   = {1'b0, shift_r} - {1'b0, step_eff};
  assign dn_next   = (dn_diff[PHASEBITS] || (dn_diff[PHASEBITS-1:0] < start_r)) ? start_r : dn_diff[PHASEBITS-1:0];
  assign turn_diff = {1'b0, stop_r} - {1'b0, step_eff};
  assign turn_next = (turn_diff[PHASEBITS] || (turn_diff[PHASEBITS-1:0] < start_r)) ? start_r : turn_diff[PHASEBITS-1:0];
  assign rise_sum  = {1'b0, start_r} + {1'b0, step_eff};
  assign rise_next = (rise_sum > {1'b0, stop_r}) ? stop_r : rise_sum[PHASEBITS-1:0];

  // Configuration registers written from the PS bus.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ctrl_en     <= 1'b0;
      ctrl_mode   <= 1'b0;
      ctrl_single <= 1'b0;
      start_r     <= '0;
      stop_r      <= '0;
      step_r      <= '0;
      dwell_r     <= '0;
    end else if (wen) begin
      case (addr)
        16'h0100: begin
          ctrl_en     <= wdata[0];
          ctrl_mode   <= wdata[1];
          ctrl_single <= wdata[2];
        end
        16'h0104: start_r <= wdata[PHASEBITS-1:0];
        16'h0108: stop_r  <= wdata[PHASEBITS-1:0];
        16'h010C: step_r  <= wdata[PHASEBITS-1:0];
        16'h0110: dwell_r <= wdata[DWELLBITS-1:0];
        default: ;
      endcase
    end
  end

  // Sweep state register; step_o marks cycles where the registered phase actually moved.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= ST_IDLE;
      shift_r     <= '0;
      dwell_cnt   <= '0;
      sweep_count <= '0;
      step_o      <= 1'b0;
    end else begin
      state       <= state_d;
      shift_r     <= shift_d;
      dwell_cnt   <= dwell_cnt_d;
      sweep_count <= sweep_count_d;
      step_o      <= (shift_d != shift_r);
    end
  end

  // Next-state logic: disable, then restart, then dwell expiry in priority order.
  always_comb begin
    state_d       = state;
    shift_d       = shift_r;
    dwell_cnt_d   = dwell_cnt;
    sweep_count_d = sweep_count;
    if (disable_wr) begin
      state_d = ST_IDLE;
      shift_d = start_r;
    end else if (restart) begin
      state_d       = ST_UP;
      shift_d       = start_r;
      dwell_cnt_d   = dwell_r;
      sweep_count_d = '0;
    end else begin
      case (state)
        ST_IDLE: shift_d = start_r;
        ST_UP, ST_DOWN: begin
          if (!expire) begin
            dwell_cnt_d = dwell_cnt - DWELLBITS'(1);
          end else begin
            dwell_cnt_d = dwell_r;
            if (degenerate) begin
              sweep_count_d = sweep_count + 32'd1;
              shift_d       = start_r;
              if (ctrl_single) state_d = ST_DONE;
            end else if (state == ST_UP) begin
              if (shift_r < stop_r) begin
                shift_d = up_next;
              end else if (!ctrl_mode) begin
                sweep_count_d = sweep_count + 32'd1;
                if (ctrl_single) state_d = ST_DONE;
                else             shift_d = start_r;
              end else begin
                state_d = ST_DOWN;
                shift_d = turn_next;
              end
            end else begin
              if (shift_r > start_r) begin
                shift_d = dn_next;
              end else begin
                sweep_count_d = sweep_count + 32'd1;
                if (ctrl_single) begin
                  state_d = ST_DONE;
                end else begin
                  state_d = ST_UP;
                  shift_d = rise_next;
                end
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Bus read-back and one-cycle acknowledge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ack   <= 1'b0;
      rdata <= '0;
    end else begin
      ack <= wen | ren;
      if (ren) begin
        case (addr)
          16'h0100: rdata <= {29'd0, ctrl_single, ctrl_mode, ctrl_en};
          16'h0104: rdata <= 32'(start_r);
          16'h0108: rdata <= 32'(stop_r);
          16'h010C: rdata <= 32'(step_r);
          16'h0110: rdata <= 32'(dwell_r);
          16'h0114: rdata <= 32'(shift_r) | (32'(state) << 16);
          16'h0118: rdata <= sweep_count;
          default:  rdata <= '0;
        endcase
      end
    end
  end

  assign shift_o = shift_r;
  assign done_o  = (state == ST_DONE);

endmodule

// File: tb/tb_red_pitaya_iq_phase_stepper.sv
// tb/tb_red_pitaya_iq_phase_stepper.sv - directed scoreboard bench for the phase stepper
module tb_red_pitaya_iq_phase_stepper;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        sync_i = 1'b0;
  logic [15:0] addr = '0;
  logic        wen = 1'b0;
  logic        ren = 1'b0;
  logic [31:0] wdata = '0;
  logic        ack;
  logic [31:0] rdata;
  logic [13:0] shift_o;
  logic        step_o;
  logic        done_o;

  typedef struct {
    logic [13:0] shift;
    int          gap;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   last_step = 0;

  red_pitaya_iq_phase_stepper #(.PHASEBITS(14), .DWELLBITS(32)) dut (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .sync_i (sync_i),
    .addr   (addr),
    .wen    (wen),
    .ren    (ren),
    .wdata  (wdata),
    .ack    (ack),
    .rdata  (rdata),
    .shift_o(shift_o),
    .step_o (step_o),
    .done_o (done_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic push(input int v, input int g);
    exp_t e;
    e.shift = v[13:0];
    e.gap   = g;
    sb.push_back(e);
  endtask

  task automatic cycle();
    exp_t e;
    @(negedge clk_i);
    cyc++;
    if (step_o === 1'b1) begin
      check("step_expected", {31'd0, sb.size() != 0}, 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("step_shift", 32'(shift_o), 32'(e.shift));
        if (e.gap != 0) check("step_gap", 32'(cyc - last_step), 32'(e.gap));
      end
      last_step = cyc;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic wr(input logic [15:0] a, input logic [31:0] d);
    addr = a; wdata = d; wen = 1'b1;
    cycle();
    wen = 1'b0;
  endtask

  task automatic rd(input logic [15:0] a, input logic [31:0] exp_v, input string tag);
    addr = a; ren = 1'b1;
    cycle();
    ren = 1'b0;
    check({tag, "_ack"}, {31'd0, ack}, 32'd1);
    check(tag, rdata, exp_v);
  endtask

  initial begin
    // reset state
    run(2);
    check("rst_shift", 32'(shift_o), 32'd0);
    check("rst_step", {31'd0, step_o}, 32'd0);
    check("rst_done", {31'd0, done_o}, 32'd0);
    check("rst_ack", {31'd0, ack}, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    rst_i = 1'b0;
    cycle();

    // sawtooth continuous 100..130 step 10 dwell 3
    push(100, 0);
    wr(16'h0104, 100); wr(16'h0108, 130); wr(16'h010C, 10); wr(16'h0110, 3);
    wr(16'h0100, 32'h1);
    last_step = cyc;
    push(110, 4); push(120, 4); push(130, 4); push(100, 4);
    run(16);
    rd(16'h0118, 32'd1, "saw_count");
    wr(16'h0100, 32'h0);
    rd(16'h0114, 32'h0000_0064, "saw_idle_status");

    // triangle single
    wr(16'h0100, 32'h7);
    last_step = cyc;
    push(110, 4); push(120, 4); push(130, 4); push(120, 4); push(110, 4); push(100, 4);
    run(27);
    check("tri_done_early", {31'd0, done_o}, 32'd0);
    run(1);
    check("tri_done", {31'd0, done_o}, 32'd1);
    rd(16'h0118, 32'd1, "tri_count");
    rd(16'h0114, 32'h0003_0064, "tri_status");
    run(5);
    check("tri_done_hold", {31'd0, done_o}, 32'd1);
    wr(16'h0100, 32'h0);
    check("tri_disable_done", {31'd0, done_o}, 32'd0);

    // full-scale clamp, dwell 0
    push(0, 0);
    wr(16'h0104, 0); wr(16'h0108, 16383); wr(16'h010C, 10000); wr(16'h0110, 0);
    wr(16'h0100, 32'h1);
    last_step = cyc;
    push(10000, 1); push(16383, 1); push(0, 1); push(10000, 1);
    run(4);
    push(0, 1);
    wr(16'h0100, 32'h0);

    // sync coincident with expiry restarts the sweep
    push(100, 0);
    wr(16'h0104, 100); wr(16'h0108, 130); wr(16'h010C, 10); wr(16'h0110, 3);
    wr(16'h0100, 32'h1);
    last_step = cyc;
    push(110, 4); push(120, 4); push(130, 4); push(100, 4); push(110, 4);
    run(22);
    rd(16'h0118, 32'd1, "sync_count_before");
    push(100, 4);
    sync_i = 1'b1;
    cycle();
    sync_i = 1'b0;
    push(110, 4);
    run(4);
    rd(16'h0118, 32'd0, "sync_count_after");
    push(100, 0);
    sync_i = 1'b1;
    wr(16'h0100, 32'h0);
    sync_i = 1'b0;
    rd(16'h0114, 32'h0000_0064, "disable_beats_sync");
    sync_i = 1'b1;
    cycle();
    sync_i = 1'b0;
    rd(16'h0114, 32'h0000_0064, "sync_while_disabled");

    // asynchronous reset mid-sweep
    wr(16'h0100, 32'h1);
    last_step = cyc;
    push(110, 4);
    run(5);
    #2 rst_i = 1'b1;
    #1;
    check("arst_shift", 32'(shift_o), 32'd0);
    check("arst_step", {31'd0, step_o}, 32'd0);
    check("arst_done", {31'd0, done_o}, 32'd0);
    check("arst_rdata", rdata, 32'd0);
    run(2);
    rst_i = 1'b0;
    run(10);
    rd(16'h0114, 32'd0, "arst_status");
    rd(16'h0100, 32'd0, "arst_ctrl");
    check("arst_sb_empty", 32'(sb.size()), 32'd0);

    // degenerate start >= stop, single sawtooth
    push(200, 0);
    wr(16'h0104, 200); wr(16'h0108, 100); wr(16'h0110, 3);
    wr(16'h0100, 32'h5);
    run(3);
    check("degen_done_early", {31'd0, done_o}, 32'd0);
    run(1);
    check("degen_done", {31'd0, done_o}, 32'd1);
    check("degen_shift", 32'(shift_o), 32'd200);
    rd(16'h0118, 32'd1, "degen_count");
    rd(16'h0104, 32'd200, "start_readback");
    rd(16'h011C, 32'd0, "unmapped_read");
    wr(16'h0100, 32'h0);
    check("degen_disable_done", {31'd0, done_o}, 32'd0);
    rd(16'h0114, 32'h0000_00C8, "degen_idle_status");

    check("final_sb_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
